// File: rtl/vector_mem_reader_if.sv
// Request/response and data-memory signals of the 16-lane vector load unit.
interface vector_mem_reader_if #(
  parameter int unsigned PIX_SIZE = 8
);
  logic                 START;
  logic [15:0]          Addr;
  logic                 BUSY;
  logic                 VALID;
  logic [15:0][15:0]    RD;
  logic [15:0]          MEM_ADDR;
  logic                 MEM_RE;
  logic [PIX_SIZE-1:0]  MEM_RD;
  logic                 ERR;

  modport slave (
    input  START, Addr, MEM_RD,
    output BUSY, VALID, RD, MEM_ADDR, MEM_RE, ERR
  );

  modport master (
    output START, Addr, MEM_RD,
    input  BUSY, VALID, RD, MEM_ADDR, MEM_RE, ERR
  );
endinterface

// File: rtl/vector_mem_reader.sv
// Loads 16 strided bytes into 16 zero-extended 16-bit lanes, one issue per cycle.
// Define VLOAD_BOUNDS_EN to suppress and flag reads beyond IMAGE_WIDTH*IMAGE_HEIGHT.
module vector_mem_reader #(
  parameter int unsigned IMAGE_WIDTH  = 120,
  parameter int unsigned IMAGE_HEIGHT = 120,
  parameter int unsigned PIX_SIZE     = 8,
  parameter int unsigned STRIDE       = 8
) (
  input logic                CLK,
  input logic                RST_N,
  vector_mem_reader_if.slave bus
);

`ifdef VLOAD_BOUNDS_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  localparam int unsigned MemDepth = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [15:0] StrideW  = 16'(STRIDE);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [15:0]          base_q;
  logic [15:0]          mem_addr_q;
  logic [3:0]           cnt_q;
  logic [14:0][15:0]    lane_q;
  logic [15:0][15:0]    rd_q;
  logic                 err_q;
  logic                 oob_prev_q;
  logic                 oob_now;
  logic [PIX_SIZE-1:0]  mem_rd;
  logic [15:0]          lane_data;

  assign mem_rd    = bus.MEM_RD;
  assign oob_now   = BoundsEn && ({16'd0, mem_addr_q} >= MemDepth);
  // Data on MEM_RD belongs to the slot issued in the previous cycle.
  assign lane_data = oob_prev_q ? 16'd0 : 16'(mem_rd);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.START) state_d = StIssue;
      StIssue: if (cnt_q == 4'd15) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.BUSY   = 1'b0;
    bus.VALID  = 1'b0;
    bus.MEM_RE = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StIssue: begin
        bus.BUSY   = 1'b1;
        bus.MEM_RE = !oob_now;
      end
      StDrain: bus.BUSY = 1'b1;
      StDone: begin
        bus.BUSY  = 1'b1;
        bus.VALID = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.MEM_ADDR = mem_addr_q;
  assign bus.RD       = rd_q;
  assign bus.ERR      = err_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      base_q     <= '0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      lane_q     <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
      oob_prev_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.START) begin
            base_q     <= bus.Addr;
            mem_addr_q <= bus.Addr;
            cnt_q      <= 4'd0;
            err_q      <= 1'b0;
          end
        end
        StIssue: begin
          oob_prev_q <= oob_now;
          if (oob_now) err_q <= 1'b1;
          if (cnt_q != 4'd0) lane_q[cnt_q - 4'd1] <= lane_data;
          // The last issued address stays on MEM_ADDR after the final slot.
          if (cnt_q != 4'd15) begin
            cnt_q      <= cnt_q + 4'd1;
            mem_addr_q <= base_q + StrideW * {12'd0, cnt_q + 4'd1};
          end
        end
        StDrain: rd_q <= {lane_data, lane_q};
        StDone:  ;
        default: ;
      endcase
    end
  end

endmodule
